// File: rtl/dnn_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dnn_mem_pkg
// Brief    : Shared types and memory-map constants for the DNN image loader.
// Revision : 1.0 - initial release
// ============================================================================
package dnn_mem_pkg;

    localparam int DEFAULT_DATA_WIDTH = 14;
    localparam int DEFAULT_ADDR_WIDTH = 16;
    localparam int DEFAULT_DEPTH      = 16'hA9BE;

    // Region bases inside the streamed image
    localparam logic [15:0] ADDR_BASE_A      = 16'h0000;
    localparam logic [15:0] ADDR_BASE_W      = 16'h0191;
    localparam logic [15:0] ADDR_BASE_LUT_L1 = 16'h29BE;
    localparam logic [15:0] ADDR_BASE_LUT_L2 = 16'h69BE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SERVE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dnn_mem_loader_fix_if.sv
`default_nettype none
// ============================================================================
// Module   : dnn_mem_loader_fix_if
// Brief    : Load-stream and read-port bundle; csum_err exists only when
//            DNN_MEM_CHECKSUM_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface dnn_mem_loader_fix_if #(
    parameter int DATA_WIDTH = 14,
    parameter int ADDR_WIDTH = 16
) ();
    logic                         load_start;
    logic                         wr_valid;
    logic signed [DATA_WIDTH-1:0] wr_data;
    logic                         wr_ready;
    logic                         load_done;
    logic        [ADDR_WIDTH-1:0] mem_addr;
    logic signed [DATA_WIDTH-1:0] mem_data;
    logic                         oob;
`ifdef DNN_MEM_CHECKSUM_EN
    logic                         csum_err;
`endif

    modport master (
        output load_start, wr_valid, wr_data, mem_addr,
        input  wr_ready, load_done, mem_data, oob
`ifdef DNN_MEM_CHECKSUM_EN
        , input csum_err
`endif
    );

    modport slave (
        input  load_start, wr_valid, wr_data, mem_addr,
        output wr_ready, load_done, mem_data, oob
`ifdef DNN_MEM_CHECKSUM_EN
        , output csum_err
`endif
    );
endinterface
`default_nettype wire

// File: rtl/dnn_mem_ram_1r1w.sv
`default_nettype none
// ============================================================================
// Module   : dnn_mem_ram_1r1w
// Brief    : One write port, one registered read port; contents never reset.
// Revision : 1.0 - initial release
// ============================================================================
module dnn_mem_ram_1r1w #(
    parameter int DATA_WIDTH = 14,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 16'hA9BE
) (
    input  wire logic                         clk,
    input  wire logic                         i_we,
    input  wire logic        [ADDR_WIDTH-1:0] i_waddr,
    input  wire logic signed [DATA_WIDTH-1:0] i_wdata,
    input  wire logic        [ADDR_WIDTH-1:0] i_raddr,
    output      logic signed [DATA_WIDTH-1:0] o_rdata
);
    localparam int                    IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] C_DEPTH = ADDR_WIDTH'(DEPTH);

    logic signed [DATA_WIDTH-1:0] r_mem_q [DEPTH];
    logic signed [DATA_WIDTH-1:0] r_rdata_q;

    // Out-of-range reads leave the register alone; the caller masks them
    always_ff @(posedge clk) begin
        if (i_we && (i_waddr < C_DEPTH)) begin
            r_mem_q[i_waddr[IDX_W-1:0]] <= i_wdata;
        end
        if (i_raddr < C_DEPTH) begin
            r_rdata_q <= r_mem_q[i_raddr[IDX_W-1:0]];
        end
    end

    assign o_rdata = r_rdata_q;

endmodule
`default_nettype wire

// File: rtl/dnn_mem_loader_fix.sv
`default_nettype none
// ============================================================================
// Module   : dnn_mem_loader_fix
// Brief    : Streams a memory image into RAM, then serves 1-cycle reads.
//            Optional trailing checksum beat: DNN_MEM_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dnn_mem_loader_fix
    import dnn_mem_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH
) (
    input wire logic           clk,
    input wire logic           rst,
    dnn_mem_loader_fix_if.slave bus
);
    localparam logic [ADDR_WIDTH-1:0] C_DEPTH = ADDR_WIDTH'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] C_LAST  = ADDR_WIDTH'(DEPTH - 1);

    state_t                       r_state_q, w_state_d;
    logic        [ADDR_WIDTH-1:0] r_wptr_q, w_wptr_d;
    logic                         r_wr_ready_q, w_wr_ready_d;
    logic                         r_load_done_q, w_load_done_d;
    logic                         r_rd_en_q, w_rd_en_d;
    logic                         r_oob_q, w_oob_d;
    logic                         w_accept;
    logic                         w_ram_we;
    logic        [ADDR_WIDTH-1:0] w_ram_waddr;
    logic signed [DATA_WIDTH-1:0] w_ram_rdata;
`ifdef DNN_MEM_CHECKSUM_EN
    logic        [DATA_WIDTH-1:0] r_sum_q, w_sum_d;
    logic                         r_csum_phase_q, w_csum_phase_d;
    logic                         r_csum_err_q, w_csum_err_d;
`endif

    // wr_ready is high exactly while in LOAD, so it qualifies the handshake
    assign w_accept = bus.wr_valid && r_wr_ready_q;

    always_comb begin
        w_state_d   = r_state_q;
        w_wptr_d    = r_wptr_q;
        w_ram_we    = 1'b0;
        w_ram_waddr = bus.load_start ? '0 : r_wptr_q;
`ifdef DNN_MEM_CHECKSUM_EN
        w_sum_d        = r_sum_q;
        w_csum_phase_d = r_csum_phase_q;
        w_csum_err_d   = r_csum_err_q;
        if (bus.load_start) begin
            w_sum_d        = '0;
            w_csum_phase_d = 1'b0;
            w_csum_err_d   = 1'b0;
        end
`endif
        unique case (r_state_q)
            IDLE, SERVE: begin
                if (bus.load_start) begin
                    w_state_d = LOAD;
                    w_wptr_d  = '0;
                end
            end
            LOAD: begin
                if (bus.load_start) begin
                    w_wptr_d = '0;
                end
                // A beat coinciding with a restart lands at address 0
                if (w_accept) begin
`ifdef DNN_MEM_CHECKSUM_EN
                    if (r_csum_phase_q && !bus.load_start) begin
                        w_state_d    = SERVE;
                        w_csum_err_d = (r_sum_q != bus.wr_data);
                    end else begin
                        w_ram_we = 1'b1;
                        w_sum_d  = (bus.load_start ? '0 : r_sum_q) + bus.wr_data;
                        if (w_ram_waddr == C_LAST) begin
                            w_csum_phase_d = 1'b1;
                        end else begin
                            w_wptr_d = w_ram_waddr + 1'b1;
                        end
                    end
`else
                    w_ram_we = 1'b1;
                    if (w_ram_waddr == C_LAST) begin
                        w_state_d = SERVE;
                    end else begin
                        w_wptr_d = w_ram_waddr + 1'b1;
                    end
`endif
                end
            end
            default: w_state_d = IDLE;
        endcase

        w_wr_ready_d  = (w_state_d == LOAD);
        w_load_done_d = (w_state_d == SERVE);
        w_rd_en_d     = (r_state_q == SERVE) && (bus.mem_addr <  C_DEPTH);
        w_oob_d       = (r_state_q == SERVE) && (bus.mem_addr >= C_DEPTH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q      <= IDLE;
            r_wptr_q       <= '0;
            r_wr_ready_q   <= 1'b0;
            r_load_done_q  <= 1'b0;
            r_rd_en_q      <= 1'b0;
            r_oob_q        <= 1'b0;
`ifdef DNN_MEM_CHECKSUM_EN
            r_sum_q        <= '0;
            r_csum_phase_q <= 1'b0;
            r_csum_err_q   <= 1'b0;
`endif
        end else begin
            r_state_q      <= w_state_d;
            r_wptr_q       <= w_wptr_d;
            r_wr_ready_q   <= w_wr_ready_d;
            r_load_done_q  <= w_load_done_d;
            r_rd_en_q      <= w_rd_en_d;
            r_oob_q        <= w_oob_d;
`ifdef DNN_MEM_CHECKSUM_EN
            r_sum_q        <= w_sum_d;
            r_csum_phase_q <= w_csum_phase_d;
            r_csum_err_q   <= w_csum_err_d;
`endif
        end
    end

    dnn_mem_ram_1r1w #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (bus.wr_data),
        .i_raddr (bus.mem_addr),
        .o_rdata (w_ram_rdata)
    );

    // RAM output register is not reset; the enable flop masks it to zero
    assign bus.mem_data  = r_rd_en_q ? w_ram_rdata : '0;
    assign bus.oob       = r_oob_q;
    assign bus.wr_ready  = r_wr_ready_q;
    assign bus.load_done = r_load_done_q;
`ifdef DNN_MEM_CHECKSUM_EN
    assign bus.csum_err  = r_csum_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dnn_mem_loader_fix.sv
`default_nettype none
// ============================================================================
// Module   : tb_dnn_mem_loader_fix
// Brief    : Directed, table-driven bench for dnn_mem_loader_fix at DEPTH=8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dnn_mem_loader_fix;

    localparam int DW    = 14;
    localparam int AW    = 16;
    localparam int DEPTH = 8;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          oob;
    } rd_vec_t;

    typedef logic [DW-1:0] img_t [DEPTH];

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    dnn_mem_loader_fix_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    dnn_mem_loader_fix #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] md;
    assign md = bus.mem_data;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Present one beat after `gap` idle cycles; bounded wait for acceptance
    task automatic send_beat(input logic [DW-1:0] d, input int gap);
        logic acc;
        int   n;
        repeat (gap) tick();
        bus.wr_valid = 1'b1;
        bus.wr_data  = d;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 20) begin
            acc = bus.wr_ready;
            tick();
            n++;
        end
        bus.wr_valid = 1'b0;
        chk("beat_accept", {31'b0, acc}, 32'd1);
    endtask

    task automatic pulse_load_start();
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
    endtask

    task automatic load_image(input img_t img, input logic [DW-1:0] csum_delta);
        logic [DW-1:0] sum;
        pulse_load_start();
        chk("ld_ready", {31'b0, bus.wr_ready}, 32'd1);
        chk("ld_done_clr", {31'b0, bus.load_done}, 32'd0);
        sum = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) chk("ld_done_early", {31'b0, bus.load_done}, 32'd0);
            send_beat(img[i], int'($urandom_range(0, 2)));
            sum = sum + img[i];
        end
`ifdef DNN_MEM_CHECKSUM_EN
        chk("ld_done_pre_csum", {31'b0, bus.load_done}, 32'd0);
        send_beat(sum + csum_delta, int'($urandom_range(0, 2)));
`else
        if (csum_delta != '0) $display("note: checksum delta ignored");
`endif
        chk("ld_done", {31'b0, bus.load_done}, 32'd1);
        chk("ld_ready_off", {31'b0, bus.wr_ready}, 32'd0);
    endtask

    task automatic rd_chk(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic o);
        bus.mem_addr = a;
        tick();
        chk("rd_data", {18'b0, md}, {18'b0, d});
        chk("rd_oob", {31'b0, bus.oob}, {31'b0, o});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rd_vec_t       vecs [12];
        img_t          img;
        logic [DW-1:0] rsum;
        logic [DW-1:0] tail [7];

        for (int i = 0; i < DEPTH; i++) vecs[i] = '{AW'(i), DW'(i + 1), 1'b0};
        vecs[8]  = '{16'd8,    14'd0, 1'b1};
        vecs[9]  = '{16'd7,    14'd8, 1'b0};
        vecs[10] = '{16'hFFFF, 14'd0, 1'b1};
        vecs[11] = '{16'd3,    14'd4, 1'b0};
        for (int i = 0; i < DEPTH; i++) img[i] = DW'(i + 1);
        tail = '{14'h2000, 14'h100, 14'h101, 14'h102, 14'h103, 14'h104, 14'h105};

        bus.load_start = 1'b0;
        bus.wr_valid   = 1'b0;
        bus.wr_data    = '0;
        bus.mem_addr   = '0;

        // Reset state
        #12;
        chk("rst_ready", {31'b0, bus.wr_ready}, 32'd0);
        chk("rst_done", {31'b0, bus.load_done}, 32'd0);
        chk("rst_data", {18'b0, md}, 32'd0);
        chk("rst_oob", {31'b0, bus.oob}, 32'd0);
`ifdef DNN_MEM_CHECKSUM_EN
        chk("rst_csum", {31'b0, bus.csum_err}, 32'd0);
`endif
        rst = 1'b0;
        tick();

        // Read while IDLE
        rd_chk(16'd0, 14'd0, 1'b0);
        chk("idle_ready", {31'b0, bus.wr_ready}, 32'd0);

        // Basic load and table-driven reads
        load_image(img, '0);
`ifdef DNN_MEM_CHECKSUM_EN
        chk("csum_ok", {31'b0, bus.csum_err}, 32'd0);
`endif
        for (int i = 0; i < 12; i++) rd_chk(vecs[i].addr, vecs[i].data, vecs[i].oob);

        // Async reset out of SERVE clears outputs without a clock edge
        bus.mem_addr = 16'd2;
        tick();
        chk("pre_rst_data", {18'b0, md}, 32'd3);
        #2 rst = 1'b1;
        #1;
        chk("srv_rst_data", {18'b0, md}, 32'd0);
        chk("srv_rst_done", {31'b0, bus.load_done}, 32'd0);
        #2 rst = 1'b0;
        tick();

        // Reset in the middle of a load
        pulse_load_start();
        for (int i = 0; i < 3; i++) send_beat(14'h30 + DW'(i), 0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_ready", {31'b0, bus.wr_ready}, 32'd0);
        chk("mid_rst_done", {31'b0, bus.load_done}, 32'd0);
        chk("mid_rst_data", {18'b0, md}, 32'd0);
        #2 rst = 1'b0;
        tick();
        chk("mid_rst_idle", {31'b0, bus.wr_ready}, 32'd0);

        // Fresh load, restart after 5 beats with a same-cycle beat
        pulse_load_start();
        for (int i = 0; i < 5; i++) send_beat(14'h20 + DW'(i), int'($urandom_range(0, 1)));
        chk("rs_ready", {31'b0, bus.wr_ready}, 32'd1);
        bus.load_start = 1'b1;
        bus.wr_valid   = 1'b1;
        bus.wr_data    = 14'h1FFF;
        tick();
        bus.load_start = 1'b0;
        bus.wr_valid   = 1'b0;
        rsum = 14'h1FFF;
        for (int i = 0; i < 7; i++) begin
            chk("rs_done_early", {31'b0, bus.load_done}, 32'd0);
            send_beat(tail[i], int'($urandom_range(0, 2)));
            rsum = rsum + tail[i];
        end
`ifdef DNN_MEM_CHECKSUM_EN
        chk("rs_done_pre_csum", {31'b0, bus.load_done}, 32'd0);
        send_beat(rsum, 0);
        chk("rs_csum", {31'b0, bus.csum_err}, 32'd0);
`else
        if (rsum == '0) $display("note: zero restart sum");
`endif
        chk("rs_done", {31'b0, bus.load_done}, 32'd1);
        rd_chk(16'd0, 14'h1FFF, 1'b0);
        rd_chk(16'd1, 14'h2000, 1'b0);
        rd_chk(16'd5, 14'h103, 1'b0);
        rd_chk(16'd7, 14'h105, 1'b0);
        rd_chk(16'd8, 14'h0, 1'b1);

`ifdef DNN_MEM_CHECKSUM_EN
        // Bad checksum flags and holds until the next load_start
        load_image(img, 14'd1);
        chk("csum_bad", {31'b0, bus.csum_err}, 32'd1);
        repeat (3) tick();
        chk("csum_hold", {31'b0, bus.csum_err}, 32'd1);
        pulse_load_start();
        chk("csum_clr", {31'b0, bus.csum_err}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
